// File: rtl/FIFO_param_pkg.sv
// Shared FIFO parameters plus the fifo_reader state type and issue-room helper.
package FIFO_param_pkg;

    localparam int WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fifo_reader_state_t;

    // True when the buffer can take one more read: buffered + in-flight - leaving < 2.
    function automatic logic issue_room(input logic [1:0] occ,
                                        input logic       inflight,
                                        input logic       pop);
        return ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
    endfunction

endpackage

// File: rtl/fifo_reader_obuf.sv
// Two-entry valid/ready output buffer: in-order push/pop, head exposed combinationally.
module fifo_reader_obuf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       occ,
    output logic [WIDTH-1:0] head_data
);

    logic [1:0][WIDTH-1:0] slot_data;
    logic                  wr_ptr_reg;
    logic                  rd_ptr_reg;
    logic [1:0]            occ_reg;
    logic [1:0]            occ_next;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            logic [WIDTH-1:0] slot_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    slot_reg <= '0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    slot_reg <= push_data;
                end
            end

            assign slot_data[gi] = slot_reg;
        end
    endgenerate

    always_comb begin
        occ_next = occ_reg;
        case ({push, pop})
            2'b10:   occ_next = occ_reg + 2'd1;
            2'b01:   occ_next = occ_reg - 2'd1;
            default: occ_next = occ_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            occ_reg    <= 2'd0;
        end else begin
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
            occ_reg <= occ_next;
        end
    end

    assign occ       = occ_reg;
    assign head_data = slot_data[rd_ptr_reg];

endmodule

// File: rtl/fifo_reader.sv
// FIFO read-side consumer feeding a valid/ready stream; counters built only
// when FIFO_READER_STATS_EN is defined, otherwise rd_count/err_count read 0.
module fifo_reader
    import FIFO_param_pkg::*;
#(
    parameter int WIDTH = FIFO_param_pkg::WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rd_data,
    input  logic             fifo_rd_err,
    output logic             fifo_rd_en,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] err_count
);

    fifo_reader_state_t state_reg;
    fifo_reader_state_t state_next;
    logic               inflight_reg;
    logic [1:0]         occ;
    logic               pop;
    logic               push;

    assign out_valid = (occ != 2'd0);
    assign pop       = out_valid & out_ready;
    assign push      = inflight_reg & ~fifo_rd_err;
    assign busy      = (state_reg != IDLE);

    // Gated by rst so no read is issued in the cycle the reset is taken.
    assign fifo_rd_en = ~rst & enable & ~fifo_empty & (state_reg != DRAIN)
                      & issue_room(occ, inflight_reg, pop);

    fifo_reader_obuf #(
        .WIDTH (WIDTH)
    ) u_obuf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (fifo_rd_data),
        .pop       (pop),
        .occ       (occ),
        .head_data (out_data)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (enable && !fifo_empty) state_next = RUN;
            end
            RUN: begin
                if (!enable)
                    state_next = DRAIN;
                else if (fifo_empty && !inflight_reg && (occ == 2'd0))
                    state_next = IDLE;
            end
            DRAIN: begin
                if (enable)
                    state_next = RUN;
                else if (!inflight_reg && (occ == 2'd0))
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            inflight_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            inflight_reg <= fifo_rd_en;
        end
    end

`ifdef FIFO_READER_STATS_EN
    logic [CNT_W-1:0] rd_count_reg;
    logic [CNT_W-1:0] err_count_reg;

    // Both counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_reg  <= '0;
            err_count_reg <= '0;
        end else if (inflight_reg) begin
            if (!fifo_rd_err && !(&rd_count_reg))
                rd_count_reg <= rd_count_reg + CNT_W'(1);
            if (fifo_rd_err && !(&err_count_reg))
                err_count_reg <= err_count_reg + CNT_W'(1);
        end
    end

    assign rd_count  = rd_count_reg;
    assign err_count = err_count_reg;
`else
    assign rd_count  = '0;
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: emulated FIFO source, queue-based reference, directed + random stimulus.
module tb_fifo_reader;
    import FIFO_param_pkg::*;

    localparam int W     = FIFO_param_pkg::WIDTH;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          fifo_empty;
    logic [W-1:0]  fifo_rd_data;
    logic          fifo_rd_err;
    logic          fifo_rd_en;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic          busy;
    logic [CW-1:0] rd_count;
    logic [CW-1:0] err_count;

    fifo_reader #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_err  (fifo_rd_err),
        .fifo_rd_en   (fifo_rd_en),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .busy         (busy),
        .rd_count     (rd_count),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         e;
        logic [W-1:0] d;
    } src_t;

    typedef struct {
        logic         en;
        logic         rdy;
        logic         rd_en;
        logic         valid;
        logic [W-1:0] data;
        logic         busy;
    } vec_t;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    // Emulated FIFO source and observed output stream
    src_t         src_q[$];
    logic         data_cycle = 1'b0;
    src_t         data_word;
    logic [W-1:0] acc_log[$];

    // Reference model: buffered words, in-flight flag, mode 0=idle 1=run 2=drain
    logic [W-1:0] mbuf[$];
    logic         m_infl = 1'b0;
    int           m_state = 0;
    int           m_rd = 0;
    int           m_err = 0;
    logic         m_zero = 1'b1;

    logic         cap_rd_en, cap_valid, cap_busy;
    logic [W-1:0] cap_data;

    function automatic logic [31:0] exp_cnt(input int v);
`ifdef FIFO_READER_STATS_EN
        return 32'(v);
`else
        return (v < 0) ? 32'd1 : 32'd0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic en, input logic rdy);
        int           occ_m;
        int           ns;
        logic         e_valid, e_pop, e_rd_en;
        logic         act_rd_en, act_take;
        logic [W-1:0] act_data;
        @(negedge clk);
        cyc++;
        rst        = r;
        enable     = en;
        out_ready  = rdy;
        fifo_empty = (src_q.size() == 0);
        if (data_cycle) begin
            fifo_rd_data = data_word.d;
            fifo_rd_err  = data_word.e;
        end else begin
            fifo_rd_data = W'($urandom);
            fifo_rd_err  = 1'($urandom_range(0, 1));
        end
        #1;
        occ_m   = mbuf.size();
        e_valid = (occ_m != 0);
        e_pop   = e_valid && rdy;
        e_rd_en = !r && en && !fifo_empty && (m_state != 2)
                  && (occ_m + int'(m_infl) - int'(e_pop) < 2);
        check("out_valid", 32'(out_valid), 32'(e_valid));
        if (e_valid)     check("out_data", 32'(out_data), 32'(mbuf[0]));
        else if (m_zero) check("out_data_rst", 32'(out_data), 32'd0);
        check("fifo_rd_en", 32'(fifo_rd_en), 32'(e_rd_en));
        check("busy", 32'(busy), 32'(m_state != 0));
        check("rd_count", 32'(rd_count), exp_cnt(m_rd));
        check("err_count", 32'(err_count), exp_cnt(m_err));
        cap_rd_en = fifo_rd_en;
        cap_valid = out_valid;
        cap_busy  = busy;
        cap_data  = out_data;
        act_rd_en = fifo_rd_en;
        act_take  = out_valid && rdy;
        act_data  = out_data;
        @(posedge clk);
        if (act_take && !r) begin
            acc_log.push_back(act_data);
            $display("tx cycle %0d: out_data=%02h", cyc, act_data);
        end
        data_cycle = 1'b0;
        if (act_rd_en && src_q.size() > 0) begin
            data_word  = src_q.pop_front();
            data_cycle = 1'b1;
        end
        if (r) begin
            mbuf.delete();
            m_infl  = 1'b0;
            m_state = 0;
            m_rd    = 0;
            m_err   = 0;
            m_zero  = 1'b1;
        end else begin
            ns = m_state;
            case (m_state)
                0: if (en && !fifo_empty) ns = 1;
                1: if (!en) ns = 2;
                   else if (fifo_empty && !m_infl && occ_m == 0) ns = 0;
                default: if (en) ns = 1;
                         else if (!m_infl && occ_m == 0) ns = 0;
            endcase
            if (e_pop) mbuf.delete(0);
            if (m_infl) begin
                if (fifo_rd_err) begin
                    if (m_err < CMAX) m_err++;
                end else begin
                    mbuf.push_back(fifo_rd_data);
                    m_zero = 1'b0;
                    if (m_rd < CMAX) m_rd++;
                end
            end
            m_infl  = act_rd_en;
            m_state = ns;
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        src_q.delete();
        acc_log.delete();
    endtask

    task automatic load(input int first, input int n, input int err_idx);
        src_t s;
        for (int i = 0; i < n; i++) begin
            s.d = W'(first + i);
            s.e = (i == err_idx);
            src_q.push_back(s);
        end
    endtask

    task automatic expect_log(input string name, input int first, input int n, input int skip);
        int k;
        k = 0;
        for (int i = 0; i < n; i++) begin
            if (i == skip) continue;
            if (k < acc_log.size())
                check(name, 32'(acc_log[k]), 32'(first + i));
            else
                check(name, 32'hDEAD, 32'(first + i));
            k++;
        end
        check({name, "_len"}, 32'(acc_log.size()), 32'(k));
    endtask

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h02, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h04, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h05, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h06, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h07, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h08, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};

        rst = 1'b1; enable = 1'b0; out_ready = 1'b0;
        fifo_empty = 1'b1; fifo_rd_data = '0; fifo_rd_err = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        // Streaming at full rate, checked against the cycle table
        load(1, 8, -1);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, tbl[i].en, tbl[i].rdy);
            check("tbl_rd_en", 32'(cap_rd_en), 32'(tbl[i].rd_en));
            check("tbl_valid", 32'(cap_valid), 32'(tbl[i].valid));
            check("tbl_busy", 32'(cap_busy), 32'(tbl[i].busy));
            if (tbl[i].valid) check("tbl_data", 32'(cap_data), 32'(tbl[i].data));
        end
        expect_log("stream", 1, 8, -1);
        check("stream_rd_count", 32'(rd_count), exp_cnt(8));

        // Backpressure: ready low for 5 cycles after first accept
        do_reset();
        load(1, 8, -1);
        for (int i = 0; i < 20; i++)
            step(1'b0, 1'b1, !(i >= 3 && i <= 7));
        expect_log("bp", 1, 8, -1);

        // Error on third word
        do_reset();
        load(1, 5, 2);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1);
        expect_log("err", 1, 5, 2);
        check("err_rd_count", 32'(rd_count), exp_cnt(4));
        check("err_err_count", 32'(err_count), exp_cnt(1));

        // Enable drops right after a single issue
        do_reset();
        load(8'h20, 4, -1);
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1);
        expect_log("drain", 8'h20, 1, -1);
        check("drain_busy", 32'(busy), 32'd0);

        // Reset with two words buffered; reading resumes at the FIFO's next word
        do_reset();
        load(8'h31, 6, -1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        acc_log.delete();
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1);
        expect_log("rst_resume", 8'h33, 4, -1);

        // Error counter saturation with 17 errored reads
        do_reset();
        for (int i = 0; i < 17; i++) begin
            src_t s;
            s.d = W'(i);
            s.e = 1'b1;
            src_q.push_back(s);
        end
        for (int i = 0; i < 22; i++) step(1'b0, 1'b1, 1'b1);
        check("sat_err_count", 32'(err_count), exp_cnt(CMAX));
        check("sat_rd_count", 32'(rd_count), exp_cnt(0));

        // Random traffic against the reference model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (src_q.size() < 3 && $urandom_range(0, 3) == 0) begin
                int n;
                n = $urandom_range(1, 4);
                for (int k = 0; k < n; k++) begin
                    src_t s;
                    s.d = W'($urandom);
                    s.e = ($urandom_range(0, 7) == 0);
                    src_q.push_back(s);
                end
            end
            step(1'($urandom_range(0, 199) == 0),
                 1'($urandom_range(0, 9) < 8),
                 1'($urandom_range(0, 9) < 7));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
